// File: rtl/dilithium_kg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dilithium_kg_sequencer
// Brief    : Runs one Dilithium core through a key generation (core reset,
//            start, seed ingest) and tags the core's output stream with its
//            segment (rho, K, s1, s2, t1, t0, tr). Reports cycles per run.
// Revision : 1.0 - initial release
// ============================================================================
module dilithium_kg_sequencer #(
    parameter  int HIGH_PERF  = 1,
    parameter  int SEC_LEVEL  = 2,
    parameter  int RST_CYCLES = 4,
    localparam int W          = (HIGH_PERF != 0) ? 64 : 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         seed_valid,
    output logic         seed_ready,
    input  logic [W-1:0] seed_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [2:0]   out_seg,
    output logic         out_last,
    output logic         done,
    output logic         busy,
    output logic [31:0]  cycle_count,
    output logic         core_rst,
    output logic         core_start,
    output logic [1:0]   core_mode,
    output logic         core_valid_i,
    input  logic         core_ready_i,
    output logic [W-1:0] core_data_i,
    input  logic         core_valid_o,
    output logic         core_ready_o,
    input  logic [W-1:0] core_data_o
);

    // Segment sizes in bits for the selected security level
    localparam int S1_BITS = (SEC_LEVEL == 5) ? 5376  : (SEC_LEVEL == 3) ? 5120  : 3072;
    localparam int S2_BITS = (SEC_LEVEL == 2) ? 3072  : 6144;
    localparam int T1_BITS = (SEC_LEVEL == 5) ? 20480 : (SEC_LEVEL == 3) ? 15360 : 10240;
    localparam int T0_BITS = (SEC_LEVEL == 5) ? 26624 : (SEC_LEVEL == 3) ? 19968 : 13312;

    localparam int CTR_W = 16;

    // Word counts, rounded up to whole bus words
    localparam logic [CTR_W-1:0] HASH_WORDS = CTR_W'((256 + W - 1) / W);
    localparam logic [CTR_W-1:0] S1_WORDS   = CTR_W'((S1_BITS + W - 1) / W);
    localparam logic [CTR_W-1:0] S2_WORDS   = CTR_W'((S2_BITS + W - 1) / W);
    localparam logic [CTR_W-1:0] T1_WORDS   = CTR_W'((T1_BITS + W - 1) / W);
    localparam logic [CTR_W-1:0] T0_WORDS   = CTR_W'((T0_BITS + W - 1) / W);
    localparam logic [CTR_W-1:0] RST_LAST   = CTR_W'(RST_CYCLES - 1);
    localparam logic [2:0]       SEG_TR     = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_START = 3'd2,
        S_SEED  = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CTR_W-1:0]  word_ctr;
    logic [CTR_W-1:0]  word_ctr_next;
    logic [2:0]        seg;
    logic [2:0]        seg_next;
    logic [31:0]       cycle_count_next;
    logic [CTR_W-1:0]  seg_words;
    logic              seg_word_last;

    assign core_mode = 2'd0;

    // Number of words in the segment currently being streamed out
    always_comb begin
        seg_words = HASH_WORDS;
        case (seg)
            3'd2:    seg_words = S1_WORDS;
            3'd3:    seg_words = S2_WORDS;
            3'd4:    seg_words = T1_WORDS;
            3'd5:    seg_words = T0_WORDS;
            default: seg_words = HASH_WORDS;
        endcase
        seg_word_last = (word_ctr == (seg_words - CTR_W'(1)));
    end

    // State, counters and run-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            word_ctr    <= '0;
            seg         <= 3'd0;
            cycle_count <= 32'd0;
        end else begin
            state       <= next_state;
            word_ctr    <= word_ctr_next;
            seg         <= seg_next;
            cycle_count <= cycle_count_next;
        end
    end

    // Next-state logic and per-state pass-through of the two data streams
    always_comb begin
        next_state       = state;
        word_ctr_next    = word_ctr;
        seg_next         = seg;
        cycle_count_next = cycle_count;
        cmd_ready        = 1'b0;
        busy             = 1'b1;
        seed_ready       = 1'b0;
        out_valid        = 1'b0;
        out_data         = '0;
        out_seg          = 3'd0;
        out_last         = 1'b0;
        done             = 1'b0;
        core_rst         = 1'b0;
        core_start       = 1'b0;
        core_valid_i     = 1'b0;
        core_data_i      = '0;
        core_ready_o     = 1'b0;

        // Every non-idle cycle belongs to the run, saturating at all-ones
        if (state != S_IDLE && cycle_count != 32'hFFFF_FFFF) begin
            cycle_count_next = cycle_count + 32'd1;
        end

        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    next_state       = S_RST;
                    word_ctr_next    = '0;
                    cycle_count_next = 32'd0;
                end
            end
            S_RST: begin
                core_rst = 1'b1;
                if (word_ctr == RST_LAST) begin
                    next_state    = S_START;
                    word_ctr_next = '0;
                end else begin
                    word_ctr_next = word_ctr + CTR_W'(1);
                end
            end
            S_START: begin
                core_start = 1'b1;
                next_state = S_SEED;
            end
            S_SEED: begin
                core_valid_i = seed_valid;
                core_data_i  = seed_data;
                seed_ready   = core_ready_i;
                if (seed_valid && core_ready_i) begin
                    if (word_ctr == (HASH_WORDS - CTR_W'(1))) begin
                        next_state    = S_OUT;
                        word_ctr_next = '0;
                        seg_next      = 3'd0;
                    end else begin
                        word_ctr_next = word_ctr + CTR_W'(1);
                    end
                end
            end
            S_OUT: begin
                out_valid    = core_valid_o;
                out_data     = core_data_o;
                core_ready_o = out_ready;
                out_seg      = seg;
                out_last     = seg_word_last;
                if (core_valid_o && out_ready) begin
                    if (seg_word_last) begin
                        word_ctr_next = '0;
                        if (seg == SEG_TR) begin
                            seg_next   = 3'd0;
                            next_state = S_DONE;
                        end else begin
                            seg_next = seg + 3'd1;
                        end
                    end else begin
                        word_ctr_next = word_ctr + CTR_W'(1);
                    end
                end
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dilithium_kg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dilithium_kg_sequencer
// Brief    : Directed bench for dilithium_kg_sequencer. Three configurations
//            (L2/W64, L2/W32, L5/W64) each with a small core model and a
//            host-side stream monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dilithium_kg_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mon_en;
    logic        cmd_valid   [3];
    logic        toggle_en   [3];
    logic        core_stall  [3];
    logic        done_v      [3];
    logic        busy_v      [3];
    logic        cmd_ready_v [3];
    logic        out_valid_v [3];
    logic [31:0] cycle_v     [3];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Expected words per segment: cfg0 L2/W64, cfg1 L2/W32, cfg2 L5/W64
    function automatic int exp_cnt(input int cfg, input int seg);
        case (seg)
            0, 1, 6: return (cfg == 1) ? 8 : 4;
            2:       return (cfg == 0) ? 48  : (cfg == 1) ? 96  : 84;
            3:       return (cfg == 0) ? 48  : 96;
            4:       return (cfg == 0) ? 160 : 320;
            5:       return (cfg == 0) ? 208 : 416;
            default: return 0;
        endcase
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int HP    = (gi == 1) ? 0 : 1;
        localparam int SL    = (gi == 2) ? 5 : 2;
        localparam int WW    = (HP != 0) ? 64 : 32;
        localparam int SEEDW = (gi == 1) ? 8 : 4;
        localparam int TOTAL = (gi == 0) ? 476 : (gi == 1) ? 952 : 928;

        logic          cmd_ready, seed_valid, seed_ready, out_valid, out_ready, out_last;
        logic          done, busy, core_rst, core_start, core_valid_i, core_ready_i;
        logic          core_valid_o, core_ready_o, out_phase;
        logic [WW-1:0] seed_data, out_data, core_data_i, core_data_o;
        logic [2:0]    out_seg;
        logic [1:0]    core_mode;
        logic [31:0]   cycle_count;
        logic [1:0]    tog = 2'd0;

        int seed_tx = 0, seed_rx = 0, seed_err = 0, out_tx = 0;
        int rx_idx = 0, exp_seg = 0, exp_pos = 0;
        int data_err = 0, seg_err = 0, last_err = 0, last_cnt = 0;
        int rstc_cnt = 0, start_cnt = 0, done_cnt = 0;
        int mir_err = 0, ready_err = 0;
        int seg_cnt [8];

        function automatic logic [WW-1:0] seed_word(input int k);
            logic [WW-1:0] v;
            v = '0;
            for (int b = 0; b < WW / 8; b++) v[8*b +: 8] = 8'(k * (WW / 8) + b);
            return v;
        endfunction

        function automatic logic [WW-1:0] kat(input int n);
            logic [63:0] v;
            v = {32'(n) * 32'h9E37_79B1, 32'(n) ^ 32'h5A5A_0F0F};
            return v[WW-1:0];
        endfunction

        dilithium_kg_sequencer #(
            .HIGH_PERF  (HP),
            .SEC_LEVEL  (SL),
            .RST_CYCLES (4)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .cmd_valid    (cmd_valid[gi]),
            .cmd_ready    (cmd_ready),
            .seed_valid   (seed_valid),
            .seed_ready   (seed_ready),
            .seed_data    (seed_data),
            .out_valid    (out_valid),
            .out_ready    (out_ready),
            .out_data     (out_data),
            .out_seg      (out_seg),
            .out_last     (out_last),
            .done         (done),
            .busy         (busy),
            .cycle_count  (cycle_count),
            .core_rst     (core_rst),
            .core_start   (core_start),
            .core_mode    (core_mode),
            .core_valid_i (core_valid_i),
            .core_ready_i (core_ready_i),
            .core_data_i  (core_data_i),
            .core_valid_o (core_valid_o),
            .core_ready_o (core_ready_o),
            .core_data_o  (core_data_o)
        );

        assign done_v[gi]      = done;
        assign busy_v[gi]      = busy;
        assign cmd_ready_v[gi] = cmd_ready;
        assign out_valid_v[gi] = out_valid;
        assign cycle_v[gi]     = cycle_count;

        // Host side: seed always offered, out_ready optionally toggles 1,0,0,1
        always @(posedge clk) tog <= tog + 2'd1;
        assign out_ready  = toggle_en[gi] ? ((tog == 2'd0) || (tog == 2'd3)) : 1'b1;
        assign seed_valid = 1'b1;
        assign seed_data  = seed_word(seed_tx);

        always @(posedge clk) begin
            if (cmd_valid[gi] && cmd_ready) seed_tx <= 0;
            else if (seed_valid && seed_ready) seed_tx <= seed_tx + 1;
        end

        // Core model: takes the seed, then emits a known word stream
        assign core_ready_i = 1'b1;
        assign core_valid_o = (seed_rx == SEEDW) && (out_tx < TOTAL) && !core_stall[gi];
        assign core_data_o  = kat(out_tx);

        always @(posedge clk) begin
            if (core_rst === 1'b1) begin
                seed_rx <= 0;
                out_tx  <= 0;
            end else begin
                if (core_valid_i && core_ready_i) begin
                    if (core_data_i !== seed_word(seed_rx)) seed_err <= seed_err + 1;
                    seed_rx <= seed_rx + 1;
                end
                if (core_valid_o && core_ready_o) out_tx <= out_tx + 1;
            end
        end

        assign out_phase = busy && (seed_tx == SEEDW) && (rx_idx < TOTAL);

        // Host monitor, sampled mid-cycle
        always @(negedge clk) begin
            if (mon_en) begin
                if (cmd_ready !== !busy) ready_err <= ready_err + 1;
                if ((core_ready_o !== (out_ready && out_phase)) ||
                    (out_valid !== (core_valid_o && out_phase)))
                    mir_err <= mir_err + 1;
                if (cmd_valid[gi] && cmd_ready) begin
                    rx_idx <= 0; exp_seg <= 0; exp_pos <= 0;
                    data_err <= 0; seg_err <= 0; last_err <= 0; last_cnt <= 0;
                    rstc_cnt <= 0; start_cnt <= 0; done_cnt <= 0;
                    for (int s = 0; s < 8; s++) seg_cnt[s] <= 0;
                end else begin
                    if (core_rst)   rstc_cnt  <= rstc_cnt + 1;
                    if (core_start) start_cnt <= start_cnt + 1;
                    if (done)       done_cnt  <= done_cnt + 1;
                    if (out_valid && out_ready) begin
                        if (out_data !== kat(rx_idx)) data_err <= data_err + 1;
                        if (out_seg !== 3'(exp_seg)) seg_err <= seg_err + 1;
                        if (out_last !== (exp_pos == exp_cnt(gi, exp_seg) - 1))
                            last_err <= last_err + 1;
                        if (out_last === 1'b1) last_cnt <= last_cnt + 1;
                        if (!$isunknown(out_seg)) seg_cnt[out_seg] <= seg_cnt[out_seg] + 1;
                        rx_idx <= rx_idx + 1;
                        if (exp_pos == exp_cnt(gi, exp_seg) - 1) begin
                            exp_seg <= exp_seg + 1;
                            exp_pos <= 0;
                        end else begin
                            exp_pos <= exp_pos + 1;
                        end
                    end
                end
            end
        end
    end

    task automatic wait_done(input int i, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done_v[i] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_run(input int i);
        @(posedge clk); #1 cmd_valid[i] = 1'b1;
        @(posedge clk); #1 cmd_valid[i] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (cmd_ready_v[i] !== 1'b1 || busy_v[i] !== 1'b0 || out_valid_v[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_handshake[%0d]: cmd_ready=%b busy=%b out_valid=%b, want 1 0 0",
                         i, cmd_ready_v[i], busy_v[i], out_valid_v[i]);
            end
            vectors++;
            if (cycle_v[i] !== 32'd0 || done_v[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_count[%0d]: cycle_count=%0d done=%b, want 0 0", i, cycle_v[i], done_v[i]);
            end
        end
        vectors++;
        if (g_cfg[0].core_rst !== 1'b0 || g_cfg[0].core_start !== 1'b0 ||
            g_cfg[0].core_mode !== 2'd0 || g_cfg[0].seed_ready !== 1'b0 ||
            g_cfg[0].out_seg !== 3'd0 || g_cfg[0].core_valid_i !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_core_side: rst=%b start=%b mode=%0d seed_ready=%b seg=%0d vi=%b, want all 0",
                     g_cfg[0].core_rst, g_cfg[0].core_start, g_cfg[0].core_mode,
                     g_cfg[0].seed_ready, g_cfg[0].out_seg, g_cfg[0].core_valid_i);
        end
        @(posedge clk); #1 rst = 1'b0; mon_en = 1'b1;
    endtask

    task automatic test_l2_w64;
        bit ok;
        int lat;
        @(posedge clk); #1 cmd_valid[0] = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 cmd_valid[0] = 1'b0;
        lat = 0;
        for (int n = 1; n < 20; n++) begin
            @(negedge clk);
            if (g_cfg[0].core_start === 1'b1) begin lat = n; break; end
        end
        vectors++;
        if (lat !== 5) begin miscompares++; $display("FAIL t1_start_latency: got %0d want 5", lat); end
        wait_done(0, 2000, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL t1_done_timeout: got 0 want 1"); end
        @(negedge clk);
        vectors++;
        if (g_cfg[0].rstc_cnt !== 4 || g_cfg[0].start_cnt !== 1 || g_cfg[0].done_cnt !== 1) begin
            miscompares++;
            $display("FAIL t1_pulses: core_rst=%0d start=%0d done=%0d want 4 1 1",
                     g_cfg[0].rstc_cnt, g_cfg[0].start_cnt, g_cfg[0].done_cnt);
        end
        vectors++;
        if (g_cfg[0].seed_rx !== 4 || g_cfg[0].seed_err !== 0) begin
            miscompares++;
            $display("FAIL t1_seed: words=%0d bad=%0d want 4 0", g_cfg[0].seed_rx, g_cfg[0].seed_err);
        end
        for (int s = 0; s < 7; s++) begin
            vectors++;
            if (g_cfg[0].seg_cnt[s] !== exp_cnt(0, s)) begin
                miscompares++;
                $display("FAIL t1_seg_count[%0d]: got %0d want %0d", s, g_cfg[0].seg_cnt[s], exp_cnt(0, s));
            end
        end
        vectors++;
        if (g_cfg[0].data_err !== 0 || g_cfg[0].seg_err !== 0 || g_cfg[0].out_tx !== 476) begin
            miscompares++;
            $display("FAIL t1_stream: data_err=%0d seg_err=%0d core_words=%0d want 0 0 476",
                     g_cfg[0].data_err, g_cfg[0].seg_err, g_cfg[0].out_tx);
        end
        vectors++;
        if (cycle_v[0] !== 32'd486) begin
            miscompares++; $display("FAIL t1_cycle_count: got %0d want 486", cycle_v[0]);
        end
    endtask

    task automatic test_l2_w32;
        bit ok;
        start_run(1);
        wait_done(1, 3000, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL t2_done_timeout: got 0 want 1"); end
        @(negedge clk);
        vectors++;
        if (g_cfg[1].seed_rx !== 8 || g_cfg[1].seed_err !== 0) begin
            miscompares++;
            $display("FAIL t2_seed: words=%0d bad=%0d want 8 0", g_cfg[1].seed_rx, g_cfg[1].seed_err);
        end
        for (int s = 0; s < 7; s++) begin
            vectors++;
            if (g_cfg[1].seg_cnt[s] !== exp_cnt(1, s)) begin
                miscompares++;
                $display("FAIL t2_seg_count[%0d]: got %0d want %0d", s, g_cfg[1].seg_cnt[s], exp_cnt(1, s));
            end
        end
        vectors++;
        if (g_cfg[1].last_cnt !== 7 || g_cfg[1].last_err !== 0) begin
            miscompares++;
            $display("FAIL t2_out_last: count=%0d misplaced=%0d want 7 0", g_cfg[1].last_cnt, g_cfg[1].last_err);
        end
        vectors++;
        if (g_cfg[1].data_err !== 0 || cycle_v[1] !== 32'd966) begin
            miscompares++;
            $display("FAIL t2_data_cycles: data_err=%0d cycles=%0d want 0 966", g_cfg[1].data_err, cycle_v[1]);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        toggle_en[2] = 1'b1;
        start_run(2);
        wait_done(2, 6000, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL t3_done_timeout: got 0 want 1"); end
        @(negedge clk);
        toggle_en[2] = 1'b0;
        for (int s = 0; s < 7; s++) begin
            vectors++;
            if (g_cfg[2].seg_cnt[s] !== exp_cnt(2, s)) begin
                miscompares++;
                $display("FAIL t3_seg_count[%0d]: got %0d want %0d", s, g_cfg[2].seg_cnt[s], exp_cnt(2, s));
            end
        end
        vectors++;
        if (g_cfg[2].data_err !== 0 || g_cfg[2].out_tx !== 928 || g_cfg[2].last_err !== 0) begin
            miscompares++;
            $display("FAIL t3_stream: data_err=%0d core_words=%0d last_err=%0d want 0 928 0",
                     g_cfg[2].data_err, g_cfg[2].out_tx, g_cfg[2].last_err);
        end
    endtask

    task automatic test_cmd_hold;
        bit ok;
        @(posedge clk); #1 cmd_valid[0] = 1'b1;
        wait_done(0, 2000, ok);
        vectors++;
        if (!ok || cmd_ready_v[0] !== 1'b0 || g_cfg[0].start_cnt !== 1) begin
            miscompares++;
            $display("FAIL t4_first_run: done=%0d cmd_ready=%b starts=%0d want 1 0 1",
                     ok, cmd_ready_v[0], g_cfg[0].start_cnt);
        end
        @(negedge clk);
        vectors++;
        if (cmd_ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL t4_idle_gap: cmd_ready=%b busy=%b want 1 0", cmd_ready_v[0], busy_v[0]);
        end
        @(posedge clk); #1 cmd_valid[0] = 1'b0;
        @(negedge clk);
        vectors++;
        if (cmd_ready_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL t4_second_start: cmd_ready=%b busy=%b want 0 1", cmd_ready_v[0], busy_v[0]);
        end
        wait_done(0, 2000, ok);
        @(negedge clk);
        vectors++;
        if (!ok || cycle_v[0] !== 32'd486 || g_cfg[0].data_err !== 0 || g_cfg[0].start_cnt !== 1) begin
            miscompares++;
            $display("FAIL t4_second_run: done=%0d cycles=%0d data_err=%0d starts=%0d want 1 486 0 1",
                     ok, cycle_v[0], g_cfg[0].data_err, g_cfg[0].start_cnt);
        end
    endtask

    task automatic test_rst_mid_run;
        bit ok;
        bit hit;
        start_run(0);
        hit = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (g_cfg[0].exp_seg == 3 && g_cfg[0].exp_pos == 10 && out_valid_v[0] === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        vectors++;
        if (!hit) begin miscompares++; $display("FAIL t5_reach_s2_word10: got 0 want 1"); end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy_v[0] !== 1'b0 || cmd_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0 ||
            cycle_v[0] !== 32'd0 || g_cfg[0].out_seg !== 3'd0 || g_cfg[0].core_rst !== 1'b0) begin
            miscompares++;
            $display("FAIL t5_after_rst: busy=%b cmd_ready=%b out_valid=%b cycles=%0d seg=%0d core_rst=%b want 0 1 0 0 0 0",
                     busy_v[0], cmd_ready_v[0], out_valid_v[0], cycle_v[0], g_cfg[0].out_seg, g_cfg[0].core_rst);
        end
        @(posedge clk); #1 rst = 1'b0;
        start_run(0);
        wait_done(0, 2000, ok);
        @(negedge clk);
        vectors++;
        if (!ok || cycle_v[0] !== 32'd486 || g_cfg[0].data_err !== 0 || g_cfg[0].seg_cnt[3] !== 48 ||
            g_cfg[0].seg_cnt[6] !== 4 || g_cfg[0].rstc_cnt !== 4) begin
            miscompares++;
            $display("FAIL t5_rerun: done=%0d cycles=%0d data_err=%0d s2=%0d tr=%0d core_rst=%0d want 1 486 0 48 4 4",
                     ok, cycle_v[0], g_cfg[0].data_err, g_cfg[0].seg_cnt[3], g_cfg[0].seg_cnt[6], g_cfg[0].rstc_cnt);
        end
    endtask

    task automatic test_core_stall;
        bit ok;
        bit hit;
        int leaks;
        start_run(0);
        hit = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (g_cfg[0].exp_seg == 5 && g_cfg[0].exp_pos == 50 && out_valid_v[0] === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        vectors++;
        if (!hit) begin miscompares++; $display("FAIL t6_reach_t0: got 0 want 1"); end
        @(posedge clk); #1 core_stall[0] = 1'b1;
        leaks = 0;
        repeat (100) begin
            @(negedge clk);
            if (out_valid_v[0] !== 1'b0) leaks++;
        end
        @(posedge clk); #1 core_stall[0] = 1'b0;
        vectors++;
        if (leaks !== 0) begin miscompares++; $display("FAIL t6_valid_in_stall: got %0d cycles want 0", leaks); end
        wait_done(0, 2000, ok);
        @(negedge clk);
        vectors++;
        if (!ok || cycle_v[0] !== 32'd586 || g_cfg[0].data_err !== 0 || g_cfg[0].seg_cnt[5] !== 208) begin
            miscompares++;
            $display("FAIL t6_stalled_run: done=%0d cycles=%0d data_err=%0d t0=%0d want 1 586 0 208",
                     ok, cycle_v[0], g_cfg[0].data_err, g_cfg[0].seg_cnt[5]);
        end
    endtask

    task automatic test_protocol;
        vectors++;
        if (g_cfg[0].mir_err !== 0 || g_cfg[0].ready_err !== 0) begin
            miscompares++;
            $display("FAIL gating_cfg0: mirror=%0d cmd_ready=%0d want 0 0", g_cfg[0].mir_err, g_cfg[0].ready_err);
        end
        vectors++;
        if (g_cfg[1].mir_err !== 0 || g_cfg[1].ready_err !== 0) begin
            miscompares++;
            $display("FAIL gating_cfg1: mirror=%0d cmd_ready=%0d want 0 0", g_cfg[1].mir_err, g_cfg[1].ready_err);
        end
        vectors++;
        if (g_cfg[2].mir_err !== 0 || g_cfg[2].ready_err !== 0) begin
            miscompares++;
            $display("FAIL gating_cfg2: mirror=%0d cmd_ready=%0d want 0 0", g_cfg[2].mir_err, g_cfg[2].ready_err);
        end
    endtask

    initial begin
        rst    = 1'b1;
        mon_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmd_valid[i]  = 1'b0;
            toggle_en[i]  = 1'b0;
            core_stall[i] = 1'b0;
        end
        test_reset;
        test_l2_w64;
        test_l2_w32;
        test_backpressure;
        test_cmd_hold;
        test_rst_mid_run;
        test_core_stall;
        test_protocol;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
